uart_transmitter: RTL and testbench

8N1 UART transmitter with an internal write FIFO. It is the transmit counterpart of the VESP UART receive path and drives the top-level `tx` pin. The core or its MMIO logic pushes bytes with a one-cycle write strobe, and the block serialises them LSB-first at a fixed baud rate derived from the system clock. Idle line level is high, and default timing is 9600 baud at 100 MHz (10417 clocks per bit, about 104167 ns).

---
 rtl/uart_transmitter.sv | 131 +++++++++++++
 tb/tb_uart_transmitter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter fed by a circular write FIFO.
// state | meaning: IDLE line high, waiting | START start bit | DATA 8 bits LSB first | STOP stop bit
module uart_transmitter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);
  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [FCNT_W-1:0] count;
  logic              push, pop;

  state_t            state, state_d;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [7:0]        shift, shift_d;
  logic              tx_d, bit_done;

  assign full     = (count == FIFO_FULL);
  assign empty    = (count == '0);
  assign push     = wr && !full;
  assign busy     = (state != IDLE) || !empty;
  assign bit_done = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + FCNT_W'(1);
      else if (pop && !push) count <= count - FCNT_W'(1);
      if (wr && full) overflow <= 1'b1;
    end
  end

  // Baud timer counts down from BIT_LAST; a bit ends on terminal count zero.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    pop        = 1'b0;
    if (state != IDLE) baud_cnt_d = bit_done ? BIT_LAST : baud_cnt - CNT_W'(1);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = mem[rptr];
          baud_cnt_d = BIT_LAST;
          state_d    = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line changes on the transition edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: time-based occupancy model feeds expected frames,
// a line monitor decodes tx and checks each frame bit-by-bit against the queue.
module tb_uart_transmitter;
  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int DEPTH    = 4;
  localparam int C        = (CLK_FREQ + BAUD / 2) / BAUD;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full, empty, busy, overflow, tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  frame_t     exp_q[$];
  logic [7:0] m_fifo[$];
  int         m_free = 0;
  logic       m_ovf = 1'b0;
  int         n_pushed = 0;

  int         mon_done = 0;
  int         mon_aborted = 0;

  uart_transmitter #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .din(din),
    .full(full),
    .empty(empty),
    .busy(busy),
    .overflow(overflow),
    .tx(tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic chk_flags();
    logic [3:0] want;
    want = {m_fifo.size() == DEPTH, m_fifo.size() == 0,
            (m_fifo.size() > 0) || (cyc < m_free), m_ovf};
    check("flags", {28'd0, full, empty, busy, overflow}, {28'd0, want});
    if (!want[1]) check("idle_tx", {31'd0, tx}, 32'd1);
  endtask

  // Called at a falling edge; models the coming rising edge e = cyc+1.
  task automatic step(input logic w, input logic [7:0] d);
    int   e;
    logic acc;
    chk_flags();
    wr  = w;
    din = d;
    e   = cyc + 1;
    acc = w && (m_fifo.size() < DEPTH);
    if (w && !acc) m_ovf = 1'b1;
    if (m_fifo.size() > 0 && e >= m_free) begin
      frame_t f;
      f.data  = m_fifo.pop_front();
      f.start = e;
      exp_q.push_back(f);
      n_pushed++;
      m_free = e + 10 * C;
    end
    if (acc) m_fifo.push_back(d);
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_fifo.size() > 0 || cyc < m_free) && guard < 20000) begin
      step(1'b0, 8'($urandom));
      guard++;
    end
    if (guard >= 20000) check("drain_timeout", 32'(guard), 32'd0);
    idle(5);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    wr = 1'b0;
    #1 check("async_reset", {27'd0, tx, full, empty, busy, overflow}, 32'b10100);
    exp_q.delete();
    m_fifo.delete();
    m_ovf  = 1'b0;
    m_free = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Line monitor: every tx sample of a frame is compared with the expected level.
  initial begin
    logic       act, has;
    int         pos, st, nbad, k;
    logic [7:0] byt;
    logic       lvl;
    frame_t     f;
    act = 1'b0;
    has = 1'b0;
    pos = 0; st = 0; nbad = 0; byt = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (act && has) mon_aborted++;
        act = 1'b0;
      end else begin
        if (!act && tx === 1'b0) begin
          act = 1'b1; pos = 0; st = cyc; nbad = 0; byt = 8'h00;
          if (exp_q.size() == 0) begin
            has = 1'b0;
            check("spurious_frame", 32'(cyc), 32'd0);
          end else begin
            has = 1'b1;
            f = exp_q.pop_front();
          end
        end
        if (act) begin
          k = pos / C;
          if (k >= 1 && k <= 8 && (pos % C) == C / 2) byt[k-1] = tx;
          if (has) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f.data[k-1];
            if (tx !== lvl) nbad++;
          end
          pos++;
          if (pos == 10 * C) begin
            act = 1'b0;
            if (has) begin
              mon_done++;
              check("frame_data", {24'd0, byt}, {24'd0, f.data});
              check("frame_start", 32'(st), 32'(f.start));
              check("frame_bit_errors", 32'(nbad), 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ew;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", {27'd0, tx, full, empty, busy, overflow}, 32'b10100);
    idle(300);

    step(1'b1, 8'h55);
    drain();

    step(1'b1, 8'h0F);
    step(1'b1, 8'hA3);
    drain();

    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    drain();

    ew = cyc + 1;
    step(1'b1, 8'h00);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    while (cyc < ew + 1 + 4 * C + 5) step(1'b0, 8'($urandom));
    do_reset();
    idle(400);

    for (int b = 0; b < 10; b += 3) begin
      for (int j = b; j < b + 3 && j < 10; j++) step(1'b1, 8'(8'h10 + j));
      drain();
    end
    check("wrap_idle", {30'd0, empty, busy}, 32'b10);

    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < ((i < 3000) ? 1 : 4)) step(1'b1, 8'($urandom));
      else step(1'b0, 8'($urandom));
    end
    drain();

    check("queue_left", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(mon_done), 32'(n_pushed - mon_aborted));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
